store_unit: RTL
===============

# store_unit

Write-side counterpart of the load extraction path. Accepts store requests (byte address, register data, access size) from the execute stage through a valid/ready handshake and buffers them in a small FIFO. Each request drains to the data-memory port as one or two word-aligned writes with byte strobes; a misaligned half-word or word is split into two beats. Stores are never sign-extended; upper register bits beyond the access size are discarded.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  ADDR_W  byte address
- req_data  in  32  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10/11 word
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte-lane strobes
- busy  out  1  FIFO non-empty or split in progress

## Operation
- Push: req_valid && req_ready writes {addr, data, size} at tail. req_ready = !full; no same-cycle bypass, even when a pop occurs.
- Base mask: byte 0001, half 0011, word/11 1111 (8-bit value). off = addr[1:0]; shifted mask M = base << off; shifted data D = {32'b0, data} << 8*off (64 bits).
- Beat 0: mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_wstrb = M[3:0], mem_wdata = D[31:0].
- Split iff M[7:4] != 0 (half at off 3; word at off 1–3).
- Beat 1: mem_addr = beat-0 address + 4 (mod 2^ADDR_W), mem_wstrb = M[7:4], mem_wdata = D[63:32].
- Unused lanes in mem_wdata are 0.
- Drain FSM, head entry only:
  - BEAT0 → pop when mem_valid && mem_ready && !split; stay BEAT0.
  - BEAT0 → BEAT1 when handshake && split; entry not popped.
  - BEAT1 → BEAT0 on handshake; entry popped.
- mem_valid = FIFO non-empty. mem_addr/wdata/wstrb are 0 when mem_valid is low.
- busy = non-empty || state == BEAT1.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers and count 0, state BEAT0. Outputs: mem_valid 0, mem_* 0, req_ready 1, busy 0.
- Reset asserted mid-split discards all entries and the pending beat 1.
- Latency: a request accepted at edge N gives mem_valid high in cycle N+1. An aligned store completes on its first mem handshake; a split store needs two handshakes, at best on consecutive cycles.
- Throughput: one beat per cycle when mem_ready is held high.
- While mem_valid && !mem_ready, all mem_* outputs are held stable. No beat is retracted.
- Full: req_ready low. The cycle after a pop, req_ready rises again.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Empty: mem_valid low. A push in the same cycle is not visible until the next cycle.

## Structure
- Shared package (store_pkg):
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - drain state enum {BEAT0, BEAT1}
  - a function returning the 8-bit base-shifted mask from size and offset
- Sub-module store_fifo: DEPTH-entry synchronous FIFO with push/pop/full/empty and combinational head read. The top level holds the lane alignment and drain FSM.

## Test plan
- Aligned stores: byte 0xAB at 0x103 → addr 0x100, strb 1000, wdata 0xAB000000. Word 0x11223344 at 0x200 → strb 1111, wdata 0x11223344, one beat.
- Split word 0xDEADBEEF at 0x1002 → beat 0: 0x1000, strb 1100, wdata 0xBEEF0000; beat 1: 0x1004, strb 0011, wdata 0x0000DEAD. Entry popped only after beat 1.
- Split half 0x1234 at 0xFFFFFFFF → beat 0: 0xFFFFFFFC, strb 1000, wdata 0x34000000; beat 1: 0x00000000, strb 0001, wdata 0x00000012 (address wrap).
- Backpressure: mem_ready low for 5 cycles with DEPTH=2.
  - Third request is stalled (req_ready 0).
  - mem_* stay stable throughout.
  - Order is preserved after release.
- Reset mid-split: assert rst_n=0 while in BEAT1 → mem_valid 0 immediately, busy 0, req_ready 1; no beat 1 is issued after release.
- Size 11 and upper-bit masking: size 11 at 0x0 behaves as a word. Byte store of 0xFFFFFF5A at 0x1 → wdata 0x00005A00, strb 0010.

Source files
------------

// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
//   Shared definitions for the store unit: access-size encodings, the drain
//   state enum, and the helper that builds the 8-bit lane mask for an access
//   of a given size at a given byte offset within a word.
// -----------------------------------------------------------------------------
package store_pkg;

    // Access size encodings (2'b11 is treated as a word).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Drain FSM: BEAT0 issues the first (or only) beat, BEAT1 the spill-over
    // beat of a store that crosses a word boundary.
    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } drain_state_e;

    // Byte-lane mask across two consecutive words: bits [3:0] cover the word
    // at the aligned address, bits [7:4] cover the next word.
    function automatic logic [7:0] shifted_mask(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage : store_pkg

// File: rtl/store_fifo.sv
// -----------------------------------------------------------------------------
// store_fifo
//   DEPTH-entry synchronous FIFO with a combinational head read.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, push_data write push_data at the tail (ignored when full)
//     pop             discard the head entry (ignored when empty)
//     head_data       current head entry (don't-care when empty)
//     full, empty     occupancy flags
//   No bypass: an entry pushed at an edge is visible at the head only after it.
// -----------------------------------------------------------------------------
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_data = storage[rd_ptr_q];

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the data array is deliberately not reset; validity is tracked by
    // count_q alone, and leaving it out lets the array map onto plain storage.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr_q] <= push_data;
    end

endmodule : store_fifo

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//   Buffers store requests from execute and drains each one to the data-memory
//   port as one or two word-aligned writes with byte strobes.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid/req_ready        request handshake
//     req_addr/req_data/req_size byte address, right-justified data, size
//     mem_valid/mem_ready        write-beat handshake
//     mem_addr/wdata/wstrb       word-aligned address, lane data, strobes
//     busy                       FIFO non-empty or a second beat pending
// -----------------------------------------------------------------------------
module store_unit
    import store_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              busy
);

    localparam int ENTRY_W = ADDR_W + 32 + 2;

    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    logic [ADDR_W-1:0]  head_addr;
    logic [31:0]        head_data;
    logic [1:0]         head_size;

    logic [1:0]         off;
    logic [7:0]         mask;
    logic [31:0]        data_m;
    logic [63:0]        lane_data;
    logic [ADDR_W-1:0]  word_addr;
    logic               split;
    logic               handshake;

    drain_state_e state_q, state_d;

    // ---------------------------------------------------------------- FIFO
    assign req_ready = !fifo_full;

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid && req_ready),
        .push_data ({req_addr, req_data, req_size}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_addr, head_data, head_size} = head;

    // ------------------------------------------------------ lane alignment
    assign off       = head_addr[1:0];
    assign mask      = shifted_mask(head_size, off);
    assign split     = |mask[7:4];
    assign word_addr = {head_addr[ADDR_W-1:2], 2'b00};

    // Discard register bits above the access size before shifting so that
    // unused lanes come out as zero.
    always_comb begin
        data_m = head_data;
        case (head_size)
            SZ_BYTE: data_m = {24'b0, head_data[7:0]};
            SZ_HALF: data_m = {16'b0, head_data[15:0]};
            default: data_m = head_data;
        endcase
    end

    assign lane_data = {32'b0, data_m} << {off, 3'b000};

    assign mem_valid = !fifo_empty;
    assign handshake = mem_valid && mem_ready;

    // ------------------------------------------------- drain FSM: register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BEAT0;
        else        state_q <= state_d;
    end

    // ----------------------------------------------- drain FSM: next state
    always_comb begin
        state_d = state_q;
        if (handshake) begin
            case (state_q)
                BEAT0:   state_d = split ? BEAT1 : BEAT0;
                BEAT1:   state_d = BEAT0;
                default: state_d = BEAT0;
            endcase
        end
    end

    // --------------------------------------------------- drain FSM: outputs
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        pop       = 1'b0;
        if (mem_valid) begin
            case (state_q)
                BEAT0: begin
                    mem_addr  = word_addr;
                    mem_wstrb = mask[3:0];
                    mem_wdata = lane_data[31:0];
                    pop       = handshake && !split;
                end
                BEAT1: begin
                    // Address wraps modulo 2^ADDR_W past the top word.
                    mem_addr  = word_addr + ADDR_W'(4);
                    mem_wstrb = mask[7:4];
                    mem_wdata = lane_data[63:32];
                    pop       = handshake;
                end
                default: begin
                    mem_addr  = '0;
                    mem_wstrb = '0;
                    mem_wdata = '0;
                    pop       = 1'b0;
                end
            endcase
        end
    end

    assign busy = !fifo_empty || (state_q == BEAT1);

endmodule : store_unit
